// File: rtl/dac_cmd_pkg.sv
// Shared types and defaults for the DAC command arbiter.
// DAC_CMD_ARBITER_INIT_EN adds the power-up INIT state and its default word.
package dac_cmd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitStart,
    StWaitDone,
    StGapWait
`ifdef DAC_CMD_ARBITER_INIT_EN
    , StInit
`endif
  } dac_state_e;

  typedef struct packed {
    logic [3:0]  comm;
    logic [3:0]  addr;
    logic [15:0] data;
  } dac_cmd_t;

  localparam logic [15:0] DefStartTo = 16'd200;
  localparam logic [15:0] DefDoneTo  = 16'd4000;
  localparam logic [7:0]  DefGap     = 8'd64;

`ifdef DAC_CMD_ARBITER_INIT_EN
  localparam logic [23:0] DefInitWord = 24'h7_0_0000;
`endif

endpackage

// File: rtl/dac_cmd_arbiter_rr.sv
// Round-robin picker: searches upward from the last granted index, pointer moves on update.
module rr_arbiter #(
  parameter int unsigned NREQ = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            update,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      grant_idx
);

  localparam logic [NREQ-1:0] OneHot0 = {{(NREQ-1){1'b0}}, 1'b1};

  logic [2:0]      ptr_q;
  logic            found;
  int unsigned     idx;
  logic [NREQ-1:0] shifted;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    shifted   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = ptr_q + k + 1;
      if (idx >= NREQ) idx = idx - NREQ;
      shifted = req >> idx;
      if (!found && shifted[0]) begin
        found     = 1'b1;
        grant     = OneHot0 << idx;
        grant_idx = 3'(idx);
      end
    end
  end

  // Pointer starts at the last index so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 3'(NREQ - 1);
    end else if (update) begin
      ptr_q <= grant_idx;
    end
  end

endmodule

// File: rtl/dac_cmd_arbiter.sv
// Shares one DAC SPI serializer between NREQ requesters with watchdogs on both phases.
// Optional power-up transfer of INIT_WORD when DAC_CMD_ARBITER_INIT_EN is defined.
module dac_cmd_arbiter
  import dac_cmd_pkg::*;
#(
  parameter int unsigned     NREQ     = 3,
  parameter int unsigned     TO_W     = 16,
  parameter logic [TO_W-1:0] START_TO = TO_W'(DefStartTo),
  parameter logic [TO_W-1:0] DONE_TO  = TO_W'(DefDoneTo),
  parameter logic [7:0]      GAP      = DefGap
`ifdef DAC_CMD_ARBITER_INIT_EN
  , parameter logic [23:0]   INIT_WORD = DefInitWord
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [4*NREQ-1:0]  req_comm,
  input  logic [4*NREQ-1:0]  req_addr,
  input  logic [16*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic               err,
  output logic               busy,
  output logic [2:0]         grant_idx,
  output logic [3:0]         dac_comm,
  output logic [3:0]         dac_addr,
  output logic [15:0]        dac_data,
  output logic               dac_start,
  input  logic               dac_active
);

  localparam logic [NREQ-1:0] OneHot0 = {{(NREQ-1){1'b0}}, 1'b1};

  dac_state_e      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  dac_cmd_t        word_q, word_d, sel_word;
  logic [2:0]      grant_q, grant_d;
  logic            start_q, start_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            err_q, err_d;
  logic            arb_update;
  logic [NREQ-1:0] arb_grant;
  logic [2:0]      arb_idx;
  logic            init_xfer;

`ifdef DAC_CMD_ARBITER_INIT_EN
  localparam dac_state_e RstState = StInit;
  logic init_q, init_d;
  assign init_xfer = init_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) init_q <= 1'b1;
    else     init_q <= init_d;
  end
`else
  localparam dac_state_e RstState = StIdle;
  assign init_xfer = 1'b0;
`endif

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .update   (arb_update),
    .grant    (arb_grant),
    .grant_idx(arb_idx)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        sel_word.comm = req_comm[4*i +: 4];
        sel_word.addr = req_addr[4*i +: 4];
        sel_word.data = req_data[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    word_d     = word_q;
    grant_d    = grant_q;
    start_d    = 1'b0;
    ack_d      = '0;
    err_d      = 1'b0;
    arb_update = 1'b0;
`ifdef DAC_CMD_ARBITER_INIT_EN
    init_d     = init_q;
`endif
    unique case (state_q)
`ifdef DAC_CMD_ARBITER_INIT_EN
      StInit: begin
        if (!dac_active) begin
          word_d  = dac_cmd_t'(INIT_WORD);
          state_d = StLoad;
        end
      end
`endif
      // Stale serializer activity blocks new grants until it clears.
      StIdle: begin
        if ((|req) && !dac_active) begin
          arb_update = 1'b1;
          grant_d    = arb_idx;
          word_d     = sel_word;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = StWaitStart;
      end
      StWaitStart: begin
        if (dac_active) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end else if (cnt_q >= START_TO) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = StGapWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!dac_active) begin
          cnt_d   = '0;
          state_d = StGapWait;
        end else if (cnt_q >= DONE_TO) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = StGapWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGapWait: begin
        if (cnt_q >= TO_W'(GAP)) begin
          timeout_d = 1'b0;
          state_d   = StIdle;
`ifdef DAC_CMD_ARBITER_INIT_EN
          init_d    = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Acknowledge lands in the first GAP_WAIT cycle.
    if (state_d == StGapWait && state_q != StGapWait) begin
      err_d = timeout_d;
      if (!init_xfer) ack_d = OneHot0 << grant_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RstState;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      word_q    <= '0;
      grant_q   <= '0;
      start_q   <= 1'b0;
      ack_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      word_q    <= word_d;
      grant_q   <= grant_d;
      start_q   <= start_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign busy      = (state_q != StIdle);
  assign grant_idx = grant_q;
  assign dac_comm  = word_q.comm;
  assign dac_addr  = word_q.addr;
  assign dac_data  = word_q.data;
  assign dac_start = start_q;

endmodule
